// File: rtl/smi_byte_align_arbiter.sv
// smi_byte_align_arbiter: shares one smiByteDataAlign aligner between NumPorts
// requesters. A grant covers one setup word plus one whole frame, so frames
// stay contiguous at the aligner input. The granted port index is prepended
// to the aux field so the aligned data can be routed back to its source.
// Build option: define SMI_BYTE_ALIGN_ARB_ROUND_ROBIN_EN for round-robin
// selection; otherwise the lowest-index requesting port wins.

module smi_byte_align_arbiter_port #(
    parameter int PortIdx = 0
) (
    input  logic [1:0] grantPort,
    input  logic       setupPhase,
    input  logic       streamPhase,
    input  logic       setupBlocked,
    input  logic       flitBlocked,
    output logic       reqSetupStop,
    output logic       reqFlitStop
);
    logic granted;

    // A port is only released on the channel that matches the current phase
    assign granted      = (grantPort == 2'(PortIdx));
    assign reqSetupStop = !(setupPhase && granted) || setupBlocked;
    assign reqFlitStop  = !(streamPhase && granted) || flitBlocked;
endmodule

module smi_byte_align_arbiter #(
    parameter int NumPorts     = 2,
    parameter int FlitWidth    = 16,
    parameter int AuxDataWidth = 1
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic [NumPorts-1:0]              reqSetupReady,
    input  logic [8*NumPorts-1:0]            reqByteOffset,
    input  logic [AuxDataWidth*NumPorts-1:0] reqSetupAux,
    output logic [NumPorts-1:0]              reqSetupStop,
    input  logic [NumPorts-1:0]              reqFlitReady,
    input  logic [8*NumPorts-1:0]            reqFlitEofc,
    input  logic [FlitWidth*8*NumPorts-1:0]  reqFlitData,
    output logic [NumPorts-1:0]              reqFlitStop,
    output logic                             setupReady,
    output logic [7:0]                       byteOffset,
    output logic [AuxDataWidth+1:0]          setupAux,
    input  logic                             setupStop,
    output logic                             smiInReady,
    output logic [7:0]                       smiInEofc,
    output logic [FlitWidth*8-1:0]           smiInData,
    input  logic                             smiInStop,
    output logic                             grantValid,
    output logic [1:0]                       grantPort
);
    localparam int DataW = FlitWidth * 8;

    typedef enum logic [1:0] {ArbIdle, ArbSetup, ArbStream} arbState_t;

    arbState_t               state;
    logic                    setupPhase, streamPhase;
    logic                    setupBlocked, flitBlocked;
    logic                    setupLoad, flitLoad;
    logic                    winValid;
    logic [1:0]              winner;
    logic                    gSetupReady, gFlitReady;
    logic [7:0]              gOffset, gEofc;
    logic [AuxDataWidth-1:0] gAux;
    logic [DataW-1:0]        gData;

    assign setupPhase   = (state == ArbSetup);
    assign streamPhase  = (state == ArbStream);
    assign setupBlocked = setupReady && setupStop;
    assign flitBlocked  = smiInReady && smiInStop;
    assign setupLoad    = setupPhase && gSetupReady && !setupBlocked;
    assign flitLoad     = streamPhase && gFlitReady && !flitBlocked;

    // Per-port stop generation
    for (genvar p = 0; p < NumPorts; p++) begin : gPort
        smi_byte_align_arbiter_port #(.PortIdx(p)) uPort (
            .grantPort    (grantPort),
            .setupPhase   (setupPhase),
            .streamPhase  (streamPhase),
            .setupBlocked (setupBlocked),
            .flitBlocked  (flitBlocked),
            .reqSetupStop (reqSetupStop[p]),
            .reqFlitStop  (reqFlitStop[p])
        );
    end

    // Route the granted port's setup and flit channels toward the output registers
    always_comb begin
        gSetupReady = 1'b0;
        gOffset     = '0;
        gAux        = '0;
        gFlitReady  = 1'b0;
        gEofc       = '0;
        gData       = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (grantPort == 2'(p)) begin
                gSetupReady = reqSetupReady[p];
                gOffset     = reqByteOffset[8*p +: 8];
                gAux        = reqSetupAux[AuxDataWidth*p +: AuxDataWidth];
                gFlitReady  = reqFlitReady[p];
                gEofc       = reqFlitEofc[8*p +: 8];
                gData       = reqFlitData[DataW*p +: DataW];
            end
        end
    end

`ifdef SMI_BYTE_ALIGN_ARB_ROUND_ROBIN_EN
    logic [1:0] rrPtr;
    logic [3:0] reqPad;
    logic [2:0] cand;

    // Round-robin pick: scan from rrPtr+1, descending loop so the nearest requester wins
    always_comb begin
        winValid = 1'b0;
        winner   = '0;
        cand     = '0;
        reqPad   = '0;
        reqPad[NumPorts-1:0] = reqSetupReady;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            cand = {1'b0, rrPtr} + 3'd1 + 3'(i);
            if (cand >= 3'(NumPorts))
                cand = cand - 3'(NumPorts);
            if (reqPad[cand[1:0]]) begin
                winValid = 1'b1;
                winner   = cand[1:0];
            end
        end
    end

    // Pointer follows the most recent winner
    always_ff @(posedge clk) begin
        if (srst)
            rrPtr <= 2'(NumPorts - 1);
        else if (state == ArbIdle && winValid)
            rrPtr <= winner;
    end
`else
    // Fixed priority pick: lowest requesting index wins
    always_comb begin
        winValid = 1'b0;
        winner   = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (reqSetupReady[i]) begin
                winValid = 1'b1;
                winner   = 2'(i);
            end
        end
    end
`endif

    // Grant state machine: hold a port from setup through its end-of-frame flit
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= ArbIdle;
            grantValid <= 1'b0;
            grantPort  <= '0;
        end else begin
            case (state)
                ArbIdle: begin
                    if (winValid) begin
                        grantPort  <= winner;
                        grantValid <= 1'b1;
                        state      <= ArbSetup;
                    end
                end
                ArbSetup: begin
                    if (setupLoad)
                        state <= ArbStream;
                end
                ArbStream: begin
                    if (flitLoad && gEofc != 8'd0) begin
                        grantValid <= 1'b0;
                        state      <= ArbIdle;
                    end
                end
                default: begin
                    grantValid <= 1'b0;
                    state      <= ArbIdle;
                end
            endcase
        end
    end

    // Output setup register: load from granted port, drain when the aligner accepts
    always_ff @(posedge clk) begin
        if (srst) begin
            setupReady <= 1'b0;
            byteOffset <= '0;
            setupAux   <= '0;
        end else if (setupLoad) begin
            setupReady <= 1'b1;
            byteOffset <= gOffset;
            setupAux   <= {grantPort, gAux};
        end else if (!setupStop) begin
            setupReady <= 1'b0;
        end
    end

    // Output flit register: load from granted port, drain when the aligner accepts
    always_ff @(posedge clk) begin
        if (srst) begin
            smiInReady <= 1'b0;
            smiInEofc  <= '0;
            smiInData  <= '0;
        end else if (flitLoad) begin
            smiInReady <= 1'b1;
            smiInEofc  <= gEofc;
            smiInData  <= gData;
        end else if (!smiInStop) begin
            smiInReady <= 1'b0;
        end
    end
endmodule

// File: tb/tb_smi_byte_align_arbiter.sv
// Directed bench for smi_byte_align_arbiter with three requesters.
// Table of single-requester frames plus hand sequences for contention,
// backpressure and reset in the middle of a frame.

module tb_smi_byte_align_arbiter;
    localparam int NP = 3;
    localparam int FW = 16;
    localparam int AW = 1;
    localparam int DW = FW * 8;

    logic                clk = 1'b0;
    logic                srst;
    logic [NP-1:0]       reqSetupReady;
    logic [8*NP-1:0]     reqByteOffset;
    logic [AW*NP-1:0]    reqSetupAux;
    logic [NP-1:0]       reqSetupStop;
    logic [NP-1:0]       reqFlitReady;
    logic [8*NP-1:0]     reqFlitEofc;
    logic [DW*NP-1:0]    reqFlitData;
    logic [NP-1:0]       reqFlitStop;
    logic                setupReady;
    logic [7:0]          byteOffset;
    logic [AW+1:0]       setupAux;
    logic                setupStop;
    logic                smiInReady;
    logic [7:0]          smiInEofc;
    logic [DW-1:0]       smiInData;
    logic                smiInStop;
    logic                grantValid;
    logic [1:0]          grantPort;

    smi_byte_align_arbiter #(.NumPorts(NP), .FlitWidth(FW), .AuxDataWidth(AW)) dut (
        .clk(clk), .srst(srst),
        .reqSetupReady(reqSetupReady), .reqByteOffset(reqByteOffset),
        .reqSetupAux(reqSetupAux), .reqSetupStop(reqSetupStop),
        .reqFlitReady(reqFlitReady), .reqFlitEofc(reqFlitEofc),
        .reqFlitData(reqFlitData), .reqFlitStop(reqFlitStop),
        .setupReady(setupReady), .byteOffset(byteOffset), .setupAux(setupAux),
        .setupStop(setupStop), .smiInReady(smiInReady), .smiInEofc(smiInEofc),
        .smiInData(smiInData), .smiInStop(smiInStop),
        .grantValid(grantValid), .grantPort(grantPort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [7:0] off;
        logic       aux;
        int         nFlits;
        logic [7:0] lastEofc;
        logic [7:0] seed;
        logic [2:0] expAux;
    } vec_t;

    typedef struct { logic [7:0] off; logic [2:0] aux; int cyc; } setupRec_t;
    typedef struct { logic [DW-1:0] data; logic [7:0] eofc; int cyc; } flitRec_t;

    setupRec_t setupQ[$];
    flitRec_t  flitQ[$];
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    int        stopViol = 0;
    logic [NP-1:0] activeMask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Aligner-side monitor; transfers are decided at the following rising edge
    always @(negedge clk) begin
        if (!srst) begin
            if (setupReady && !setupStop)
                setupQ.push_back(setupRec_t'{byteOffset, setupAux, cyc});
            if (smiInReady && !smiInStop)
                flitQ.push_back(flitRec_t'{smiInData, smiInEofc, cyc});
            for (int p = 0; p < NP; p++)
                if (!activeMask[p] && (!reqSetupStop[p] || !reqFlitStop[p]))
                    stopViol++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] flitData(input logic [7:0] s, input int k);
        logic [7:0] b;
        b = s + 8'(k);
        return {16{b}};
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic syncIn();
        @(posedge clk);
        #1;
    endtask

    // Wait for a handshake on port p; sampled mid-cycle, taken at the rising edge
    task automatic waitXfer(input int p, input bit isSetup, output bit ok);
        bit stopped;
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            stopped = isSetup ? reqSetupStop[p] : reqFlitStop[p];
            @(posedge clk);
            #1;
            ok = !stopped;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake timeout: port %0d setup=%0d got no transfer expected one", p, isSetup);
        end
    endtask

    task automatic sendFrame(input int p, input logic [7:0] off, input logic aux, input int n,
                             input logic [7:0] lastEofc, input logic [7:0] seed);
        bit ok;
        reqByteOffset[8*p +: 8] = off;
        reqSetupAux[p]          = aux;
        reqSetupReady[p]        = 1'b1;
        waitXfer(p, 1'b1, ok);
        reqSetupReady[p] = 1'b0;
        for (int k = 0; k < n && ok; k++) begin
            reqFlitData[DW*p +: DW] = flitData(seed, k);
            reqFlitEofc[8*p +: 8]   = (k == n - 1) ? lastEofc : 8'h00;
            reqFlitReady[p]         = 1'b1;
            waitXfer(p, 1'b0, ok);
        end
        reqFlitReady[p] = 1'b0;
    endtask

    task automatic newScenario(input logic [NP-1:0] mask);
        syncIn();
        setupQ.delete();
        flitQ.delete();
        activeMask = mask;
        stopViol   = 0;
    endtask

    vec_t vecs[4];
    int   startCyc;
    int   expOff[4];
    int   expSeed[4];
    int   expAx[4];
    int   n;
    bit   ok;

    initial begin
        vecs[0] = '{1, 8'd5,  1'b1, 3, 8'd7,  8'h10, 3'b011};
        vecs[1] = '{0, 8'd15, 1'b0, 1, 8'd16, 8'h20, 3'b000};
        vecs[2] = '{2, 8'd0,  1'b1, 2, 8'h80, 8'h30, 3'b101};
        vecs[3] = '{2, 8'd9,  1'b0, 4, 8'h01, 8'h38, 3'b100};

        srst = 1'b1;
        reqSetupReady = '0; reqByteOffset = '0; reqSetupAux = '0;
        reqFlitReady = '0; reqFlitEofc = '0; reqFlitData = '0;
        setupStop = 1'b0; smiInStop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst setupReady", setupReady, 0);
        check("rst smiInReady", smiInReady, 0);
        check("rst grantValid", grantValid, 0);
        check("rst grantPort", grantPort, 0);
        check("rst reqSetupStop", reqSetupStop, 3'b111);
        check("rst reqFlitStop", reqFlitStop, 3'b111);
        syncIn();
        srst = 1'b0;

        // Single-requester frames
        for (int i = 0; i < 4; i++) begin
            newScenario(NP'(1) << vecs[i].port);
            startCyc = cyc;
            sendFrame(vecs[i].port, vecs[i].off, vecs[i].aux, vecs[i].nFlits, vecs[i].lastEofc, vecs[i].seed);
            @(negedge clk);
            check("idle after eof", grantValid, 0);
            repeat (3) @(negedge clk);
            check("setup count", setupQ.size(), 1);
            if (setupQ.size() > 0) begin
                check("byteOffset", setupQ[0].off, vecs[i].off);
                check("setupAux", setupQ[0].aux, vecs[i].expAux);
                check("setup latency", setupQ[0].cyc - startCyc, 2);
            end
            check("flit count", flitQ.size(), vecs[i].nFlits);
            for (int k = 0; k < vecs[i].nFlits && k < flitQ.size(); k++)
                check("flit eofc+data", {flitQ[k].eofc, flitQ[k].data},
                      {(k == vecs[i].nFlits - 1) ? vecs[i].lastEofc : 8'h00, flitData(vecs[i].seed, k)});
            check("idle port stops", stopViol, 0);
        end

        // Contention: ports 0 and 1, two frames each, requesting together
`ifdef SMI_BYTE_ALIGN_ARB_ROUND_ROBIN_EN
        expOff = '{1, 3, 2, 4}; expSeed = '{'h40, 'h50, 'h44, 'h54}; expAx = '{0, 3, 0, 3};
`else
        expOff = '{1, 2, 3, 4}; expSeed = '{'h40, 'h44, 'h50, 'h54}; expAx = '{0, 0, 3, 3};
`endif
        newScenario(3'b011);
        fork
            begin
                sendFrame(0, 8'h01, 1'b0, 2, 8'h01, 8'h40);
                sendFrame(0, 8'h02, 1'b0, 2, 8'h01, 8'h44);
            end
            begin
                sendFrame(1, 8'h03, 1'b1, 2, 8'h01, 8'h50);
                sendFrame(1, 8'h04, 1'b1, 2, 8'h01, 8'h54);
            end
        join
        repeat (3) @(negedge clk);
        check("cont setup count", setupQ.size(), 4);
        check("cont flit count", flitQ.size(), 8);
        for (int j = 0; j < 4 && j < setupQ.size() && 2*j+1 < flitQ.size(); j++) begin
            check("cont order offset", setupQ[j].off, expOff[j]);
            check("cont order aux", setupQ[j].aux, expAx[j]);
            check("cont flit0", {flitQ[2*j].eofc, flitQ[2*j].data}, {8'h00, flitData(8'(expSeed[j]), 0)});
            check("cont flit1", {flitQ[2*j+1].eofc, flitQ[2*j+1].data}, {8'h01, flitData(8'(expSeed[j]), 1)});
            if (j > 0)
                check("cont frame gap", setupQ[j].cyc - flitQ[2*j-1].cyc, 2);
        end
        check("cont port2 stops", stopViol, 0);

        // Backpressure: aligner stops for 4 cycles mid-frame on port 2
        newScenario(3'b100);
        fork
            sendFrame(2, 8'h22, 1'b0, 6, 8'h05, 8'h60);
            begin : stall
                int w;
                w = 0;
                while (flitQ.size() < 2 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                check("bp reached mid-frame", flitQ.size() >= 2, 1);
                @(posedge clk);
                #1 smiInStop = 1'b1;
                @(negedge clk);
                n = flitQ.size();
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp data hold", smiInData, flitData(8'h60, n));
                    check("bp smiInReady", smiInReady, 1);
                    check("bp reqFlitStop", reqFlitStop[2], 1);
                end
                check("bp no transfer", flitQ.size(), n);
                @(posedge clk);
                #1 smiInStop = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("bp flit count", flitQ.size(), 6);
        for (int k = 0; k < 6 && k < flitQ.size(); k++)
            check("bp flit seq", {flitQ[k].eofc, flitQ[k].data},
                  {(k == 5) ? 8'h05 : 8'h00, flitData(8'h60, k)});

        // Reset mid-stream on port 1, with an early flit offered alongside setup
        newScenario(3'b010);
        reqByteOffset[15:8] = 8'h44;
        reqSetupAux[1]      = 1'b0;
        reqSetupReady[1]    = 1'b1;
        reqFlitData[2*DW-1:DW] = flitData(8'h80, 0);
        reqFlitEofc[15:8]   = 8'h00;
        reqFlitReady[1]     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("early flit held", reqFlitStop[1], 1);
        check("setup released", reqSetupStop[1], 0);
        syncIn();
        reqSetupReady[1] = 1'b0;
        waitXfer(1, 1'b0, ok);
        reqFlitData[2*DW-1:DW] = flitData(8'h80, 1);
        waitXfer(1, 1'b0, ok);
        reqFlitData[2*DW-1:DW] = flitData(8'h80, 2);
        srst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid rst smiInReady", smiInReady, 0);
        check("mid rst setupReady", setupReady, 0);
        check("mid rst grantValid", grantValid, 0);
        check("mid rst reqSetupStop", reqSetupStop, 3'b111);
        check("mid rst reqFlitStop", reqFlitStop, 3'b111);
        srst = 1'b0;
        reqFlitReady = '0;

        newScenario(3'b001);
        startCyc = cyc;
        sendFrame(0, 8'h33, 1'b1, 1, 8'h02, 8'h70);
        repeat (3) @(negedge clk);
        check("post rst setup count", setupQ.size(), 1);
        if (setupQ.size() > 0) begin
            check("post rst offset", setupQ[0].off, 8'h33);
            check("post rst aux", setupQ[0].aux, 3'b001);
            check("post rst latency", setupQ[0].cyc - startCyc, 2);
        end
        check("post rst flit count", flitQ.size(), 1);
        if (flitQ.size() > 0)
            check("post rst flit", {flitQ[0].eofc, flitQ[0].data}, {8'h02, flitData(8'h70, 0)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
